pipe_skid_reg: RTL and testbench



---
 rtl/pipe_skid_reg.sv | 107 ++++++++++
 tb/tb_pipe_skid_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry and flush.
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   flush      discard all held entries at the next edge
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   stage accepts in_data this cycle (flop when SKID=1, combinational when SKID=0)
//   out_valid  out_data is valid
//   out_data   payload to downstream stage, BUBBLE while empty
//   out_ready  downstream accepts this cycle
//   count      number of entries held (0..2)
module pipe_skid_reg #(
    parameter int unsigned       WIDTH  = 32,
    parameter int unsigned       SKID   = 1,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic             in_fire;
    logic             main_free;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_d;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_d;

    // Next-state for the main and skid entries.
    always_comb begin
        in_fire      = in_valid & in_ready;
        main_free    = ~out_valid | out_ready;
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;

        if (main_free) begin
            if (skid_valid) begin
                // Older skid payload goes first; a new arrival refills the skid.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_data_d = in_data;
                end
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = BUBBLE;
            end
        end else if (in_fire && (SKID != 0)) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Entry registers; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid  <= 1'b0;
            out_data   <= BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            count      <= 2'd0;
        end else begin
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            count      <= 2'({1'b0, out_valid_d} + {1'b0, skid_valid_d});
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            // Registered ready: mirrors an empty skid entry, no path from out_ready.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= ~skid_valid_d;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // SKID=1, BUBBLE=0
    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_count;

    // SKID=0, BUBBLE=0
    logic        z_flush = 1'b0, z_in_valid = 1'b0, z_out_ready = 1'b0;
    logic [31:0] z_in_data = '0;
    logic        z_in_ready, z_out_valid;
    logic [31:0] z_out_data;
    logic [1:0]  z_count;

    // SKID=1, BUBBLE=4
    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .SKID(1), .BUBBLE(32'h0)) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(s_out_ready), .count(s_count));

    pipe_skid_reg #(.WIDTH(32), .SKID(0), .BUBBLE(32'h0)) u_noskid (
        .clk(clk), .rst(rst), .flush(z_flush), .in_valid(z_in_valid), .in_data(z_in_data),
        .in_ready(z_in_ready), .out_valid(z_out_valid), .out_data(z_out_data),
        .out_ready(z_out_ready), .count(z_count));

    pipe_skid_reg #(.WIDTH(32), .SKID(1), .BUBBLE(32'h4)) u_bub (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(b_out_ready), .count(b_count));

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", s_out_valid); end
        n_vec++; if (s_out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", s_out_data); end
        n_vec++; if (s_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", s_count); end
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", s_in_ready); end
        n_vec++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_noskid got %0b want 1", z_in_ready); end
        n_vec++; if (z_count !== 2'd0) begin n_err++; $display("FAIL reset_count_noskid got %0d want 0", z_count); end
        n_vec++; if (b_out_data !== 32'h4) begin n_err++; $display("FAIL reset_bubble got %h want 4", b_out_data); end
    endtask

    task automatic test_stream();
        s_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 32'(i);
            #1;
            n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, s_in_ready); end
            cyc();
            n_vec++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out_valid[%0d] got %0b want 1", i, s_out_valid); end
            n_vec++; if (s_out_data !== 32'(i)) begin n_err++; $display("FAIL stream_out_data[%0d] got %h want %h", i, s_out_data, 32'(i)); end
            n_vec++; if (s_count !== 2'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d want 1", i, s_count); end
        end
        s_in_valid = 1'b0;
        cyc();
        n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid got %0b want 0", s_out_valid); end
        n_vec++; if (s_out_data !== 32'h0) begin n_err++; $display("FAIL stream_drain_data got %h want 0", s_out_data); end
        n_vec++; if (s_count !== 2'd0) begin n_err++; $display("FAIL stream_drain_count got %0d want 0", s_count); end
    endtask

    task automatic test_stall();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hA;
        cyc();
        n_vec++; if (s_out_data !== 32'hA || s_count !== 2'd1 || s_in_ready !== 1'b1) begin n_err++;
            $display("FAIL stall_first got data=%h count=%0d ready=%0b want A/1/1", s_out_data, s_count, s_in_ready); end
        s_in_data = 32'hB;
        cyc();
        n_vec++; if (s_out_data !== 32'hA || s_count !== 2'd2 || s_in_ready !== 1'b0) begin n_err++;
            $display("FAIL stall_full got data=%h count=%0d ready=%0b want A/2/0", s_out_data, s_count, s_in_ready); end
        s_in_data = 32'hC;
        cyc();
        n_vec++; if (s_out_data !== 32'hA || s_count !== 2'd2 || s_in_ready !== 1'b0) begin n_err++;
            $display("FAIL stall_hold got data=%h count=%0d ready=%0b want A/2/0", s_out_data, s_count, s_in_ready); end
        // Release: skid moves to main, C still offered but not yet accepted.
        s_out_ready = 1'b1;
        cyc();
        n_vec++; if (s_out_valid !== 1'b1 || s_out_data !== 32'hB || s_count !== 2'd1 || s_in_ready !== 1'b1) begin n_err++;
            $display("FAIL stall_release_b got valid=%0b data=%h count=%0d ready=%0b want 1/B/1/1", s_out_valid, s_out_data, s_count, s_in_ready); end
        cyc();
        s_in_valid = 1'b0;
        n_vec++; if (s_out_valid !== 1'b1 || s_out_data !== 32'hC || s_count !== 2'd1) begin n_err++;
            $display("FAIL stall_release_c got valid=%0b data=%h count=%0d want 1/C/1", s_out_valid, s_out_data, s_count); end
        cyc();
        n_vec++; if (s_out_valid !== 1'b0 || s_out_data !== 32'h0 || s_count !== 2'd0) begin n_err++;
            $display("FAIL stall_empty got valid=%0b data=%h count=%0d want 0/0/0", s_out_valid, s_out_data, s_count); end
    endtask

    task automatic test_flush();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'h11;
        cyc();
        s_in_data = 32'h12;
        cyc();
        n_vec++; if (s_count !== 2'd2) begin n_err++; $display("FAIL flush_prefill got count=%0d want 2", s_count); end
        s_flush   = 1'b1;
        s_in_data = 32'hD;
        cyc();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        n_vec++; if (s_out_valid !== 1'b0 || s_out_data !== 32'h0 || s_count !== 2'd0 || s_in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_full got valid=%0b data=%h count=%0d ready=%0b want 0/0/0/1", s_out_valid, s_out_data, s_count, s_in_ready); end
        // Flush with a real in_fire (one entry held, ready high): payload discarded.
        s_in_valid = 1'b1;
        s_in_data  = 32'h21;
        cyc();
        s_flush   = 1'b1;
        s_in_data = 32'hD;
        cyc();
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (s_out_valid !== 1'b0 || s_out_data !== 32'h0) begin n_err++;
                $display("FAIL flush_discard[%0d] got valid=%0b data=%h want 0/0", i, s_out_valid, s_out_data); end
            cyc();
        end
    endtask

    task automatic test_rst_mid_stall();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'h31;
        cyc();
        s_in_data = 32'h32;
        cyc();
        rst         = 1'b1;
        s_out_ready = 1'b1;
        cyc();
        rst        = 1'b0;
        s_in_valid = 1'b0;
        n_vec++; if (s_out_valid !== 1'b0 || s_out_data !== 32'h0 || s_count !== 2'd0 || s_in_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_mid_stall got valid=%0b data=%h count=%0d ready=%0b want 0/0/0/1", s_out_valid, s_out_data, s_count, s_in_ready); end
    endtask

    task automatic test_bubble();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h55;
        #1;
        // Empty stage accepting: no bypass, out_valid stays low this cycle.
        n_vec++; if (b_out_valid !== 1'b0 || b_out_data !== 32'h4) begin n_err++;
            $display("FAIL bubble_no_bypass got valid=%0b data=%h want 0/4", b_out_valid, b_out_data); end
        cyc();
        b_in_valid = 1'b0;
        n_vec++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h55) begin n_err++;
            $display("FAIL bubble_load got valid=%0b data=%h want 1/55", b_out_valid, b_out_data); end
        cyc();
        n_vec++; if (b_out_valid !== 1'b0 || b_out_data !== 32'h4 || b_count !== 2'd0) begin n_err++;
            $display("FAIL bubble_drain got valid=%0b data=%h count=%0d want 0/4/0", b_out_valid, b_out_data, b_count); end
    endtask

    task automatic test_noskid_random();
        logic [31:0] q[$];
        logic        exp_ready;
        logic        of;
        logic        inf;
        for (int c = 0; c < 10000; c++) begin
            z_in_valid  = 1'($urandom_range(0, 1));
            z_out_ready = 1'($urandom_range(0, 1));
            z_in_data   = $urandom;
            #1;
            exp_ready = (q.size() == 0) || z_out_ready;
            n_vec++; if (z_in_ready !== exp_ready) begin n_err++;
                $display("FAIL noskid_ready[%0d] got %0b want %0b", c, z_in_ready, exp_ready); end
            n_vec++; if (z_out_valid !== (q.size() != 0)) begin n_err++;
                $display("FAIL noskid_valid[%0d] got %0b want %0b", c, z_out_valid, (q.size() != 0)); end
            n_vec++; if (z_count !== 2'(q.size())) begin n_err++;
                $display("FAIL noskid_count[%0d] got %0d want %0d", c, z_count, q.size()); end
            if (q.size() != 0) begin
                n_vec++; if (z_out_data !== q[0]) begin n_err++;
                    $display("FAIL noskid_data[%0d] got %h want %h", c, z_out_data, q[0]); end
            end else begin
                n_vec++; if (z_out_data !== 32'h0) begin n_err++;
                    $display("FAIL noskid_bubble[%0d] got %h want 0", c, z_out_data); end
            end
            of  = (q.size() != 0) && z_out_ready;
            inf = z_in_valid && exp_ready;
            if (of) void'(q.pop_front());
            if (inf) q.push_back(z_in_data);
            cyc();
        end
        z_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_rst_mid_stall();
        test_bubble();
        test_noskid_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
